// File: rtl/vga_pkg.sv
// Shared types and constants for the pixel pattern generator.
package vga_pkg;

    // Displayed test pattern
    typedef enum logic [1:0] {
        MODE_BARS     = 2'd0,
        MODE_SOLID    = 2'd1,
        MODE_STRIPES  = 2'd2,
        MODE_INV_BARS = 2'd3
    } mode_t;

    // 12-bit colours as {R,G,B} nibbles
    localparam logic [11:0] COL_WHITE = 12'hFFF;
    localparam logic [11:0] COL_RED   = 12'hF00;
    localparam logic [11:0] COL_GREEN = 12'h0F0;
    localparam logic [11:0] COL_BLUE  = 12'h00F;

    // Four equal colour bars across the active width
    function automatic int unsigned bar_width(input int unsigned hvid);
        return hvid / 4;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioning: 2-flop synchronizer, stability counter and
// rising-edge detector producing a one-cycle press pulse.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 250000
) (
    input  logic clk_25,
    input  logic n_rst,
    input  logic btn_raw,
    output logic press_pulse
);

    localparam int unsigned CW = ($clog2(DEBOUNCE_CYC + 1) < 1) ? 1 : $clog2(DEBOUNCE_CYC + 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          level_q;
    logic [CW-1:0] cnt;

    // Bring the raw button into the clk_25 domain
    always_ff @(posedge clk_25 or negedge n_rst) begin
        if (!n_rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // Accept a new level only after it has differed for DEBOUNCE_CYC cycles in a row
    always_ff @(posedge clk_25 or negedge n_rst) begin
        if (!n_rst) begin
            level   <= 1'b0;
            level_q <= 1'b0;
            cnt     <= '0;
        end else begin
            level_q <= level;
            if (sync2 != level) begin
                if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
                    level <= sync2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign press_pulse = level & ~level_q;

endmodule

// File: rtl/pixel_pattern_gen.sv
// Test-pattern pixel generator: colour bars / solid / stripes / inverted bars,
// selected by a debounced button and applied on frame boundaries.
// Optional feature: define AUTO_CYCLE_EN to also advance the mode every
// AUTO_FRAMES frames.
module pixel_pattern_gen
    import vga_pkg::*;
#(
    parameter int unsigned HVID         = 640,
    parameter int unsigned DEBOUNCE_CYC = 250000,
    parameter int unsigned AUTO_FRAMES  = 120
) (
    input  logic       clk_25,
    input  logic       n_rst,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       video_on,
    input  logic [9:0] horizontal_num,
    input  logic       mode_btn,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic [1:0] mode,
    output logic [7:0] frame_cnt
);

    localparam int unsigned BAR_W = bar_width(HVID);

    mode_t       mode_q;
    logic        pending;
    logic        press;
    logic        frame_edge;
    logic        auto_hit;
    logic [9:0]  bar_idx;
    logic [11:0] bar_col;
    logic [11:0] pix;

    btn_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_btn_debounce (
        .clk_25     (clk_25),
        .n_rst      (n_rst),
        .btn_raw    (mode_btn),
        .press_pulse(press)
    );

    // vsync_out doubles as the registered vsync used for edge detection
    assign frame_edge = vsync_in & ~vsync_out;
    assign mode       = mode_q;

`ifdef AUTO_CYCLE_EN
    localparam int unsigned AW = ($clog2(AUTO_FRAMES) < 1) ? 1 : $clog2(AUTO_FRAMES);

    logic [AW-1:0] auto_cnt;

    assign auto_hit = frame_edge && (auto_cnt == AW'(AUTO_FRAMES - 1));

    // Count frames between automatic mode advances
    always_ff @(posedge clk_25 or negedge n_rst) begin
        if (!n_rst) begin
            auto_cnt <= '0;
        end else if (frame_edge) begin
            auto_cnt <= auto_hit ? '0 : auto_cnt + AW'(1);
        end
    end
`else
    // Auto-advance compiled out; AUTO_FRAMES is kept only so the parameter list
    // is identical in both builds.
    assign auto_hit = (AUTO_FRAMES == 0) && 1'b0;
`endif

    // Pattern colour for the current input pixel
    always_comb begin
        bar_idx = 10'(32'(horizontal_num) / BAR_W);
        case (bar_idx)
            10'd0:   bar_col = COL_WHITE;
            10'd1:   bar_col = COL_RED;
            10'd2:   bar_col = COL_GREEN;
            default: bar_col = COL_BLUE;
        endcase
        pix = '0;
        if (video_on && (32'(horizontal_num) < HVID)) begin
            case (mode_q)
                MODE_BARS:     pix = bar_col;
                MODE_SOLID:    pix = COL_WHITE;
                MODE_STRIPES:  pix = horizontal_num[3] ? COL_WHITE : '0;
                MODE_INV_BARS: pix = ~bar_col;
            endcase
        end
    end

    // Register pixel colour and syncs together for a uniform one-cycle latency
    always_ff @(posedge clk_25 or negedge n_rst) begin
        if (!n_rst) begin
            red       <= '0;
            green     <= '0;
            blue      <= '0;
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
        end else begin
            {red, green, blue} <= pix;
            hsync_out          <= hsync_in;
            vsync_out          <= vsync_in;
        end
    end

    // Mode/pending/frame counter; a press on a frame edge is held for the next edge
    always_ff @(posedge clk_25 or negedge n_rst) begin
        if (!n_rst) begin
            mode_q    <= MODE_BARS;
            pending   <= 1'b0;
            frame_cnt <= '0;
        end else if (frame_edge) begin
            frame_cnt <= frame_cnt + 8'd1;
            if (pending || auto_hit) begin
                mode_q <= mode_t'(mode_q + 2'd1);
            end
            pending <= press;
        end else if (press) begin
            pending <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pixel_pattern_gen.sv
// Self-checking bench for pixel_pattern_gen (scoreboard of per-cycle expectations).
module tb_pixel_pattern_gen;

    localparam int unsigned DB = 4;
    localparam int unsigned AF = 3;

    logic       clk_25 = 1'b0;
    logic       n_rst = 1'b0;
    logic       hsync_in = 1'b0;
    logic       vsync_in = 1'b0;
    logic       video_on = 1'b0;
    logic [9:0] horizontal_num = '0;
    logic       mode_btn = 1'b0;
    logic [3:0] red, green, blue;
    logic       hsync_out, vsync_out;
    logic [1:0] mode;
    logic [7:0] frame_cnt;

    always #20 clk_25 = ~clk_25;

    pixel_pattern_gen #(
        .HVID(640),
        .DEBOUNCE_CYC(DB),
        .AUTO_FRAMES(AF)
    ) u_dut (
        .clk_25(clk_25),
        .n_rst(n_rst),
        .hsync_in(hsync_in),
        .vsync_in(vsync_in),
        .video_on(video_on),
        .horizontal_num(horizontal_num),
        .mode_btn(mode_btn),
        .red(red),
        .green(green),
        .blue(blue),
        .hsync_out(hsync_out),
        .vsync_out(vsync_out),
        .mode(mode),
        .frame_cnt(frame_cnt)
    );

    typedef struct packed {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        logic [1:0]  md;
        logic [7:0]  fc;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference model state
    logic [1:0]  exp_mode = 2'd0;
    logic        exp_pending = 1'b0;
    logic [7:0]  exp_frame = 8'd0;
    logic        prev_vs = 1'b0;
    int unsigned exp_auto = 0;

    function automatic logic [11:0] ref_rgb(input logic [1:0] md, input logic von, input logic [9:0] col);
        logic [11:0] bar;
        if (!von || col >= 10'd640) return 12'h000;
        if (col < 10'd160)      bar = 12'hFFF;
        else if (col < 10'd320) bar = 12'hF00;
        else if (col < 10'd480) bar = 12'h0F0;
        else                    bar = 12'h00F;
        case (md)
            2'd0:    return bar;
            2'd1:    return 12'hFFF;
            2'd2:    return col[3] ? 12'hFFF : 12'h000;
            default: return ~bar;
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Drive one input cycle, record the expectation, then compare after the edge
    task automatic step(input logic von, input logic [9:0] col, input logic hs, input logic vs, input logic btn);
        exp_t e;
        logic adv;
        video_on       = von;
        horizontal_num = col;
        hsync_in       = hs;
        vsync_in       = vs;
        mode_btn       = btn;
        e.rgb = ref_rgb(exp_mode, von, col);
        e.hs  = hs;
        e.vs  = vs;
        if (vs && !prev_vs) begin
            adv = exp_pending;
`ifdef AUTO_CYCLE_EN
            if (exp_auto == AF - 1) begin
                exp_auto = 0;
                adv = 1'b1;
            end else begin
                exp_auto++;
            end
`endif
            exp_frame++;
            if (adv) exp_mode++;
            exp_pending = 1'b0;
        end
        prev_vs = vs;
        e.md = exp_mode;
        e.fc = exp_frame;
        sb.push_back(e);

        @(posedge clk_25);
        #1;
        check_eq("sb_depth", sb.size(), 1);
        e = sb.pop_front();
        check_eq("rgb", {red, green, blue}, e.rgb);
        check_eq("hsync_out", hsync_out, e.hs);
        check_eq("vsync_out", vsync_out, e.vs);
        check_eq("mode", mode, e.md);
        check_eq("frame_cnt", frame_cnt, e.fc);
    endtask

    task automatic press(input int unsigned n_high);
        for (int i = 0; i < int'(n_high); i++) step(1'b0, 10'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic frame_edge();
        step(1'b0, 10'd0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic sweep();
        int cols[12] = '{0, 7, 8, 159, 160, 319, 320, 479, 480, 639, 640, 1023};
        for (int i = 0; i < 12; i++) step(1'b1, 10'(cols[i]), 1'(i % 2), 1'b0, 1'b0);
        step(1'b0, 10'd100, 1'b0, 1'b0, 1'b0);
    endtask

    // Assert reset away from a clock edge, check async clear, release cleanly
    task automatic reset_dut();
        n_rst = 1'b0;
        #1;
        check_eq("rst_rgb", {red, green, blue}, 12'h000);
        check_eq("rst_hsync", hsync_out, 1'b0);
        check_eq("rst_vsync", vsync_out, 1'b0);
        check_eq("rst_mode", mode, 2'd0);
        check_eq("rst_frame", frame_cnt, 8'd0);
        video_on = 1'b0; horizontal_num = '0; hsync_in = 1'b0; vsync_in = 1'b0; mode_btn = 1'b0;
        repeat (2) @(posedge clk_25);
        #1;
        check_eq("rst_hold_rgb", {red, green, blue}, 12'h000);
        sb.delete();
        exp_mode = 2'd0; exp_pending = 1'b0; exp_frame = 8'd0; prev_vs = 1'b0; exp_auto = 0;
        n_rst = 1'b1;
    endtask

    initial begin
        #2ms;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] fc0;
        #5;
        reset_dut();

        // Bars across the line, blanking and out-of-range clamp
        sweep();

        // Short press is rejected
        press(2);
        frame_edge();

        // Accepted press takes effect at the next frame edge
        press(6);
        exp_pending = 1'b1;
        frame_edge();
        sweep();

        // Two presses before one edge advance only once
        press(6);
        exp_pending = 1'b1;
        press(6);
        frame_edge();
        sweep();

        // Press detected on the same cycle as the vsync rise waits for the next edge
        for (int i = 0; i < 6; i++) step(1'b0, 10'd0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 10'd0, 1'b0, 1'b1, 1'b0);
        exp_pending = 1'b1;
        for (int i = 0; i < 10; i++) step(1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
        frame_edge();
        sweep();

        // Reach mode 3, leave a press pending, reset mid-line
        for (int k = 0; k < 8; k++) begin
            if (exp_mode == 2'd3) break;
            press(6);
            exp_pending = 1'b1;
            frame_edge();
        end
        check_eq("mode_before_reset", mode, 2'd3);
        press(6);
        exp_pending = 1'b1;
        step(1'b1, 10'd300, 1'b1, 1'b0, 1'b0);
        step(1'b1, 10'd301, 1'b1, 1'b0, 1'b0);
        reset_dut();
        step(1'b1, 10'd300, 1'b1, 1'b0, 1'b0);
        frame_edge();
        check_eq("mode_after_reset_edge", mode, 2'd0);
        sweep();

        // frame_cnt wraps after 256 edges
        fc0 = exp_frame;
        repeat (256) frame_edge();
        check_eq("frame_wrap", frame_cnt, fc0);

`ifdef AUTO_CYCLE_EN
        reset_dut();
        repeat (3) frame_edge();
        check_eq("auto_3rd_edge", mode, 2'd1);
        repeat (3) frame_edge();
        check_eq("auto_6th_edge", mode, 2'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
